// File: rtl/cskip_pkg.sv
// Shared constants and FSM state type for the carry-skip add/subtract family.
package cskip_pkg;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_SLICE      = 8;
  localparam int DEF_NUM_SLICES = DEF_WIDTH / DEF_SLICE;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/cskip_sub_slice.sv
// One carry-skip subtract slice: a + ~b + cin, with the propagate-all bypass.
module cskip_sub_slice #(
  parameter int SLICE = 8
)(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             p
);
  logic [SLICE-1:0] bn;
  logic [SLICE:0]   rip;

  assign bn  = ~b;
  assign rip = {1'b0, a} + {1'b0, bn} + {{SLICE{1'b0}}, cin};
  assign sum = rip[SLICE-1:0];
  // When every bit propagates the ripple carry equals cin, so the bypass is exact.
  assign p    = &(a ^ bn);
  assign cout = p ? cin : rip[SLICE];
endmodule

// File: rtl/cskip_sub_seq32.sv
// Sequential carry-skip subtractor: one slice per cycle, ready/valid on both sides.
module cskip_sub_seq32
  import cskip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE,
  localparam int NS   = WIDTH / SLICE,
  localparam int CW   = $clog2(NS) + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero,
  output logic [CW-1:0]    skip_cnt
);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  state_t                   state;
  logic [NS-1:0][SLICE-1:0] a_q, b_q, diff_q, diff_nx;
  logic                     c_q;
  logic [IW-1:0]            idx;
  logic [SLICE-1:0]         s_sum;
  logic                     s_cout, s_p;

  cskip_sub_slice #(.SLICE(SLICE)) u_slice (
    .a(a_q[idx]), .b(b_q[idx]), .cin(c_q),
    .sum(s_sum), .cout(s_cout), .p(s_p)
  );

  always_comb begin
    diff_nx      = diff_q;
    diff_nx[idx] = s_sum;
  end

  assign in_ready = (state == IDLE);
  assign Diff     = diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      idx       <= '0;
      diff_q    <= '0;
      out_valid <= 1'b0;
      Bout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      skip_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= A;
          b_q      <= B;
          c_q      <= ~Bin;
          idx      <= '0;
          diff_q   <= '0;
          Bout     <= 1'b0;
          Ovf      <= 1'b0;
          Zero     <= 1'b0;
          skip_cnt <= '0;
          state    <= CALC;
        end
        CALC: begin
          diff_q   <= diff_nx;
          c_q      <= s_cout;
          skip_cnt <= skip_cnt + CW'(s_p);
          if (idx == IW'(NS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            Bout      <= ~s_cout;
            // Overflow only possible when operand signs differ.
            Ovf       <= (a_q[NS-1][SLICE-1] != b_q[NS-1][SLICE-1]) &&
                         (diff_nx[NS-1][SLICE-1] != a_q[NS-1][SLICE-1]);
            Zero      <= (diff_nx == '0);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
